// File: rtl/eq_stream_if.sv
// eq_stream_if: paired ILA/HLS AXI-stream pixel buses feeding the equivalence checker
interface eq_stream_if #(parameter int DATA_WIDTH = 8);
  logic [DATA_WIDTH-1:0] ila_TDATA;
  logic                  ila_TVALID;
  logic                  ila_TREADY;
  logic [DATA_WIDTH-1:0] hls_TDATA;
  logic                  hls_TVALID;
  logic                  hls_TLAST;
  logic                  hls_TREADY;
  modport master (output ila_TDATA, ila_TVALID, hls_TDATA, hls_TVALID, hls_TLAST,
                  input  ila_TREADY, hls_TREADY);
  modport slave  (input  ila_TDATA, ila_TVALID, hls_TDATA, hls_TVALID, hls_TLAST,
                  output ila_TREADY, hls_TREADY);
endinterface

// File: rtl/eq_stream_checker.sv
// eq_stream_checker: buffers ILA and HLS pixel streams and reports one PASS/FAIL/STALL verdict per frame
module eq_stream_checker #(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 4,
  parameter int FRAME_PIXELS = 316224,
  parameter int SKEW_LIMIT   = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  eq_stream_if.slave            s,
  output logic [18:0]           match_cnt,
  output logic                  done,
  output logic                  fail,
  output logic                  stall,
  output logic [18:0]           fail_idx,
  output logic [DATA_WIDTH-1:0] fail_ila,
  output logic [DATA_WIDTH:0]   fail_hls
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  typedef enum logic [1:0] {RUN, PASS, FAIL, STALL} state_t;
  state_t state, state_n;
  logic [DATA_WIDTH-1:0] ila_mem [DEPTH];
  logic [DATA_WIDTH:0]   hls_mem [DEPTH];
  logic [AW-1:0] ila_wp, ila_rp, hls_wp, hls_rp;
  logic [AW:0] ila_cnt, hls_cnt;
  logic [18:0] idx;
  logic [7:0] skew, skew_n;
  logic ila_rdy, hls_rdy, ila_push, hls_push, pop, last, eq, skew_on;
  logic [DATA_WIDTH-1:0] ila_head;
  logic [DATA_WIDTH:0]   hls_head;
  assign ila_rdy = ila_cnt != FULL && state == RUN && !rst;
  assign hls_rdy = hls_cnt != FULL && state == RUN && !rst;
  assign s.ila_TREADY = ila_rdy;
  assign s.hls_TREADY = hls_rdy;
  always_comb begin
    ila_push = s.ila_TVALID && ila_rdy;
    hls_push = s.hls_TVALID && hls_rdy;
    ila_head = ila_mem[ila_rp];
    hls_head = hls_mem[hls_rp];
    pop = state == RUN && ila_cnt != '0 && hls_cnt != '0;
    last = idx == 19'(FRAME_PIXELS - 1);
    eq = ila_head == hls_head[DATA_WIDTH-1:0] && hls_head[DATA_WIDTH] == last;
    skew_on = (ila_cnt == FULL && hls_cnt == '0) || (hls_cnt == FULL && ila_cnt == '0);
    skew_n = skew_on ? skew + 8'd1 : 8'd0;
    state_n = state != RUN ? state :
              pop ? (!eq ? FAIL : last ? PASS : RUN) :
              skew_on && skew_n == 8'(SKEW_LIMIT) ? STALL : RUN;
  end
  always_ff @(posedge clk)
    if (rst) state <= RUN;
    else state <= state_n;
  // Storage needs no reset: the cleared counts make stale entries unreachable
  always_ff @(posedge clk) begin
    if (ila_push) ila_mem[ila_wp] <= s.ila_TDATA;
    if (hls_push) hls_mem[hls_wp] <= {s.hls_TLAST, s.hls_TDATA};
  end
  always_ff @(posedge clk)
    if (rst) begin
      ila_wp <= '0;
      ila_rp <= '0;
      hls_wp <= '0;
      hls_rp <= '0;
      ila_cnt <= '0;
      hls_cnt <= '0;
      idx <= '0;
      skew <= '0;
      match_cnt <= '0;
      done <= 1'b0;
      fail <= 1'b0;
      stall <= 1'b0;
      fail_idx <= '0;
      fail_ila <= '0;
      fail_hls <= '0;
    end else begin
      if (ila_push) ila_wp <= ila_wp + 1'b1;
      if (hls_push) hls_wp <= hls_wp + 1'b1;
      if (pop) ila_rp <= ila_rp + 1'b1;
      if (pop) hls_rp <= hls_rp + 1'b1;
      ila_cnt <= ila_cnt + {{AW{1'b0}}, ila_push} - {{AW{1'b0}}, pop};
      hls_cnt <= hls_cnt + {{AW{1'b0}}, hls_push} - {{AW{1'b0}}, pop};
      if (state == RUN) skew <= skew_n;
      if (pop && eq) begin
        match_cnt <= match_cnt + 19'd1;
        idx <= idx + 19'd1;
      end
      if (pop && !eq) begin
        fail_idx <= idx;
        fail_ila <= ila_head;
        fail_hls <= hls_head;
      end
      done <= state_n == PASS;
      fail <= state_n == FAIL;
      stall <= state_n == STALL;
    end
endmodule

// File: tb/tb_eq_stream_checker.sv
// tb_eq_stream_checker: directed frame vectors plus hand-timed sequences for the stream checker
module tb_eq_stream_checker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  eq_stream_if #(.DATA_WIDTH(8)) bus();
  logic [18:0] match_cnt, fail_idx;
  logic done, fail, stall;
  logic [7:0] fail_ila;
  logic [8:0] fail_hls;
  eq_stream_checker #(.DATA_WIDTH(8), .DEPTH(4), .FRAME_PIXELS(16), .SKEW_LIMIT(10)) dut (
    .clk(clk), .rst(rst), .s(bus), .match_cnt(match_cnt), .done(done), .fail(fail),
    .stall(stall), .fail_idx(fail_idx), .fail_ila(fail_ila), .fail_hls(fail_hls));
  int errors = 0;
  int checks = 0;
  typedef struct {
    int ila_dly, hls_dly, ila_bad, hls_bad;
    logic [7:0] ila_val, hls_val;
    int last_at;
    logic e_done, e_fail;
    int e_match, e_idx;
    logic [7:0] e_ila;
    logic [8:0] e_hls;
  } vec_t;
  vec_t v [8];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [7:0] pix(input int i);
    return 8'(i * 7 + 3);
  endfunction
  task automatic do_reset();
    rst = 1'b1;
    bus.ila_TVALID = 1'b0;
    bus.hls_TVALID = 1'b0;
    bus.hls_TLAST = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_ila_ready", bus.ila_TREADY, 0);
    chk("rst_hls_ready", bus.hls_TREADY, 0);
    chk("rst_outputs", {match_cnt, done, fail, stall, fail_idx, fail_ila, fail_hls}, 0);
    rst = 1'b0;
  endtask
  task automatic drive_ila(input vec_t t);
    int i = 0;
    logic acc;
    for (int c = 0; c < 60; c++) begin
      bus.ila_TVALID = c >= t.ila_dly && i < 16;
      bus.ila_TDATA = i == t.ila_bad ? t.ila_val : pix(i);
      @(negedge clk);
      acc = bus.ila_TVALID && bus.ila_TREADY;
      @(posedge clk);
      #1;
      if (acc) i++;
    end
    bus.ila_TVALID = 1'b0;
  endtask
  task automatic drive_hls(input vec_t t);
    int i = 0;
    logic acc;
    for (int c = 0; c < 60; c++) begin
      bus.hls_TVALID = c >= t.hls_dly && i < 16;
      bus.hls_TDATA = i == t.hls_bad ? t.hls_val : pix(i);
      bus.hls_TLAST = i == t.last_at;
      @(negedge clk);
      acc = bus.hls_TVALID && bus.hls_TREADY;
      @(posedge clk);
      #1;
      if (acc) i++;
    end
    bus.hls_TVALID = 1'b0;
  endtask
  task automatic run_vec(input int n, input vec_t t);
    fork
      drive_ila(t);
      drive_hls(t);
      if (t.hls_dly >= 7) begin
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("skew_ila_ready_low", bus.ila_TREADY, 0);
        chk("skew_no_match_yet", match_cnt, 0);
      end
    join
    chk($sformatf("v%0d_done", n), done, t.e_done);
    chk($sformatf("v%0d_fail", n), fail, t.e_fail);
    chk($sformatf("v%0d_stall", n), stall, 0);
    chk($sformatf("v%0d_match_cnt", n), match_cnt, t.e_match);
    chk($sformatf("v%0d_fail_idx", n), fail_idx, t.e_idx);
    chk($sformatf("v%0d_fail_ila", n), fail_ila, t.e_ila);
    chk($sformatf("v%0d_fail_hls", n), fail_hls, t.e_hls);
    chk($sformatf("v%0d_readys_low", n), {bus.ila_TREADY, bus.hls_TREADY}, 0);
  endtask
  initial begin
    v[0] = '{0, 0, -1, -1, 8'h00, 8'h00, 15, 1'b1, 1'b0, 16, 0, 8'h00, 9'h000};
    v[1] = '{0, 0, 5, 5, 8'h3D, 8'h3C, 15, 1'b0, 1'b1, 5, 5, 8'h3D, 9'h03C};
    v[2] = '{0, 0, -1, -1, 8'h00, 8'h00, 9, 1'b0, 1'b1, 9, 9, 8'h42, 9'h142};
    v[3] = '{0, 7, -1, -1, 8'h00, 8'h00, 15, 1'b1, 1'b0, 16, 0, 8'h00, 9'h000};
    v[4] = '{5, 2, -1, -1, 8'h00, 8'h00, 15, 1'b1, 1'b0, 16, 0, 8'h00, 9'h000};
    v[5] = '{0, 0, 0, -1, 8'hFC, 8'h00, 15, 1'b0, 1'b1, 0, 0, 8'hFC, 9'h003};
    v[6] = '{0, 0, 15, -1, 8'h00, 8'h00, 15, 1'b0, 1'b1, 15, 15, 8'h00, 9'h16C};
    v[7] = '{0, 0, -1, -1, 8'h00, 8'h00, -1, 1'b0, 1'b1, 15, 15, 8'h6C, 9'h06C};
    bus.ila_TDATA = '0;
    bus.hls_TDATA = '0;
    for (int n = 0; n < 8; n++) begin
      do_reset();
      run_vec(n, v[n]);
    end
    do_reset();
    for (int e = 1; e <= 17; e++) begin
      bus.ila_TVALID = 1'b1;
      bus.hls_TVALID = 1'b1;
      bus.ila_TDATA = pix(e - 1);
      bus.hls_TDATA = pix(e - 1);
      bus.hls_TLAST = e - 1 == 15;
      @(posedge clk);
      #1;
      if (e == 16) chk("lock_done_not_early", done, 0);
      if (e == 17) begin
        chk("lock_done_edge17", done, 1);
        chk("lock_match16", match_cnt, 16);
      end
    end
    do_reset();
    bus.ila_TVALID = 1'b1;
    bus.ila_TDATA = 8'h55;
    for (int e = 1; e <= 14; e++) begin
      @(posedge clk);
      #1;
      if (e == 4) chk("stall_ila_full_ready", bus.ila_TREADY, 0);
      if (e == 13) chk("stall_not_early", stall, 0);
      if (e == 14) begin
        chk("stall_set", stall, 1);
        chk("stall_match0", match_cnt, 0);
        chk("stall_hls_ready", bus.hls_TREADY, 0);
      end
    end
    do_reset();
    run_vec(8, v[1]);
    do_reset();
    #1;
    chk("post_rst_ready", {bus.ila_TREADY, bus.hls_TREADY}, 2'b11);
    run_vec(9, v[0]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/eq_stream_checker.md
# eq_stream_checker

Downstream consumer for the Gaussian-blur equivalence wrapper. It accepts the two 8-bit output pixel streams, ILA `arg_0` and HLS `arg_0` with TLAST, and buffers each side in its own small FIFO to absorb latency skew. It compares the streams pixel-by-pixel in arrival order and reports a single pass, fail or stall verdict per frame, with capture of the first divergence. It holds no reference model; it only checks that the two streams agree.

## Interface
- `DATA_WIDTH`, 8, pixel width.
- `DEPTH`, 4, entries per side FIFO; power of two, ≥ 2.
- `FRAME_PIXELS`, 316224, output pixels per frame (488×648); must fit 19 bits.
- `SKEW_LIMIT`, 255, maximum cycles one side may stay full while the other is empty; 8-bit counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ila_TDATA`  in  8  ILA output pixel.
- `ila_TVALID`  in  1  ILA pixel valid.
- `ila_TREADY`  out  1  checker can accept an ILA pixel.
- `hls_TDATA`  in  8  HLS output pixel.
- `hls_TVALID`  in  1  HLS pixel valid.
- `hls_TLAST`  in  1  HLS end-of-frame marker.
- `hls_TREADY`  out  1  checker can accept an HLS pixel.
- `match_cnt`  out  19  pixels compared equal.
- `done`  out  1  sticky; frame compared fully equal (PASS).
- `fail`  out  1  sticky; data or TLAST divergence (FAIL).
- `stall`  out  1  sticky; skew limit exceeded (STALL).
- `fail_idx`  out  19  pixel index of first divergence.
- `fail_ila`  out  8  ILA pixel at `fail_idx`.
- `fail_hls`  out  9  {TLAST, pixel} from HLS at `fail_idx`.

## Operation
- **ILA FIFO.** 8 bits wide, DEPTH entries, read and write pointers plus a count.
- **HLS FIFO.** 9 bits wide, {TLAST, data}, same structure.
- **Accept and ready.**
  - A side accepts a beat when `x_TVALID & x_TREADY`.
  - `x_TREADY = !full & (state==RUN) & !rst`.
- **Simultaneous push and pop** on the same FIFO is allowed; count is unchanged and data order is preserved. A full FIFO cannot be pushed because TREADY is low.
- **Compare.** In RUN, when both FIFOs are non-empty, pop both heads in the same cycle and compare them.
  - Pixel index `idx` (19-bit) is the number of pops so far.
  - `expected_last = (idx == FRAME_PIXELS-1)`.
  - Equal means `ila_head == hls_head[7:0]` and `hls_head[8] == expected_last`.
  - Equal and not last: `match_cnt` increments, `idx` increments.
  - Equal and last: `match_cnt` increments, state goes to PASS, `done` is set.
  - Unequal: state goes to FAIL, `fail` is set, and `fail_idx`, `fail_ila`, `fail_hls` are captured. `match_cnt` does not increment.
- **Skew counter.**
  - Increments each RUN cycle in which one FIFO is full and the other is empty.
  - Clears on any other RUN cycle.
  - Reaching SKEW_LIMIT moves the state to STALL and sets `stall`.
- **State machine.** States are RUN, PASS, FAIL, STALL.
  - RUN to PASS, FAIL or STALL as above.
  - PASS, FAIL and STALL are terminal until `rst`.
  - In terminal states both TREADYs are 0 and the FIFOs are frozen.
- **Priority within one cycle:** compare result (PASS or FAIL) over STALL. Both conditions cannot coexist, since a compare requires both FIFOs non-empty.
- **No wrap.** `idx` and `match_cnt` never exceed FRAME_PIXELS, because PASS halts counting.

## Timing
- **Reset values.**
  - All outputs are 0, including both TREADYs while `rst` is high.
  - State RUN, FIFOs empty, skew counter 0.
  - TREADYs go to 1 on the first cycle after `rst` deasserts.
- **Reset mid-operation.** `rst` clears everything, including sticky flags and captured data, on the next edge. No partial state survives.
- **Latency.** A beat accepted at edge k is compared and popped at edge k+1 at the earliest. `match_cnt`, the flags and the captures are visible after that edge.
- **Throughput.** One comparison per cycle.
- **Terminal-edge TREADY.** TREADY drops the cycle after the terminal transition. A beat accepted on the transition edge stays in its FIFO and is never compared.
- **Registered outputs.** All outputs come from registers. TREADY is a combinational function of registers and `rst` only, with no path from TVALID.

## Test plan
- **Lock-step frame.** Identical streams, both TVALID held at 1, FRAME_PIXELS=16 override, TLAST on beat 15 → `done`=1 at edge 17 after reset release, `match_cnt`=16, `fail`=0, `stall`=0.
- **Data mismatch.** HLS beat 5 = 0x3C, ILA beat 5 = 0x3D → `fail`=1, `fail_idx`=5, `fail_ila`=0x3D, `fail_hls`=0x03C, `match_cnt`=5, both TREADY=0 afterwards.
- **TLAST error.** HLS TLAST on beat 9 of 16 → `fail`=1, `fail_idx`=9, `fail_hls[8]`=1, `done`=0.
- **Skew absorbed.** ILA sends 4 beats, then HLS starts 3 cycles later → `ila_TREADY`=0 while that FIFO is full; matching resumes without error; `done` is set at the end.
- **Stall.** ILA fills its FIFO and HLS never valid, SKEW_LIMIT=10 → `stall`=1 after 10 full/empty cycles, `match_cnt`=0.
- **Reset mid-frame.** `rst` pulsed after `fail` is set → next cycle all outputs 0 and both TREADY low; the cycle after, TREADY=1 and a new clean frame passes.
